// File: rtl/comparator.sv
// Registered magnitude comparator: samples A/B while in_valid is high and
// presents one-hot less/equal/greater flags one clock later.
module comparator #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_less_B,
    output logic             A_equal_B,
    output logic             A_greater_B
);

    logic             sign_flip;
    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             lt;
    logic             eq;
    logic             gt;

    logic             valid_d, valid_q;
    logic             less_d, less_q;
    logic             equal_d, equal_q;
    logic             greater_d, greater_q;

    assign sign_flip = (SIGNED != 0);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned compare serves both modes.
    always_comb begin
        a_cmp            = A;
        b_cmp            = B;
        a_cmp[WIDTH-1]   = A[WIDTH-1] ^ sign_flip;
        b_cmp[WIDTH-1]   = B[WIDTH-1] ^ sign_flip;
        lt               = (a_cmp < b_cmp);
        eq               = (A == B);
        gt               = ~lt & ~eq;
    end

    // Next state: load fresh flags on a valid sample, otherwise hold them.
    always_comb begin
        valid_d   = in_valid;
        less_d    = less_q;
        equal_d   = equal_q;
        greater_d = greater_q;
        if (in_valid) begin
            less_d    = lt;
            equal_d   = eq;
            greater_d = gt;
        end
    end

    // Result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            greater_q <= greater_d;
        end
    end

    assign out_valid   = valid_q;
    assign A_less_B    = less_q;
    assign A_equal_B   = equal_q;
    assign A_greater_B = greater_q;

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator: one unsigned and one signed WIDTH=2 instance
// share the same stimulus; each is checked against hand-computed flags.
module tb_comparator;

    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] exp_u;
        logic [2:0] exp_s;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;

    logic u_valid, u_lt, u_eq, u_gt;
    logic s_valid, s_lt, s_eq, s_gt;

    int checks;
    int errors;

    vec_t vecs[16];

    comparator #(.WIDTH(2), .SIGNED(0)) dut_u (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .A           (a),
        .B           (b),
        .out_valid   (u_valid),
        .A_less_B    (u_lt),
        .A_equal_B   (u_eq),
        .A_greater_B (u_gt)
    );

    comparator #(.WIDTH(2), .SIGNED(1)) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .A           (a),
        .B           (b),
        .out_valid   (s_valid),
        .A_less_B    (s_lt),
        .A_equal_B   (s_eq),
        .A_greater_B (s_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid/lt/eq/gt=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [3:0] exp_u,
                              input logic [3:0] exp_s);
        check({name, " unsigned"}, {u_valid, u_lt, u_eq, u_gt}, exp_u);
        check({name, " signed"}, {s_valid, s_lt, s_eq, s_gt}, exp_s);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Unsigned sweep
        vecs[0]  = '{2'd0, 2'd0, EQ, EQ};
        vecs[1]  = '{2'd0, 2'd1, LT, LT};
        vecs[2]  = '{2'd0, 2'd2, LT, GT};
        vecs[3]  = '{2'd0, 2'd3, LT, GT};
        vecs[4]  = '{2'd3, 2'd0, GT, LT};
        vecs[5]  = '{2'd3, 2'd1, GT, LT};
        vecs[6]  = '{2'd3, 2'd2, GT, GT};
        vecs[7]  = '{2'd3, 2'd3, EQ, EQ};
        // Back-to-back sequence
        vecs[8]  = '{2'd0, 2'd1, LT, LT};
        vecs[9]  = '{2'd1, 2'd1, EQ, EQ};
        vecs[10] = '{2'd2, 2'd1, GT, LT};
        vecs[11] = '{2'd3, 2'd3, EQ, EQ};
        // Signed-focused pairs, including the sign boundary 10 vs 01
        vecs[12] = '{2'd1, 2'd2, LT, GT};
        vecs[13] = '{2'd2, 2'd2, EQ, EQ};
        vecs[14] = '{2'd2, 2'd3, LT, LT};
        vecs[15] = '{2'd1, 2'd0, GT, GT};

        // Reset state
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_both("reset held", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_both("idle after reset", 4'b0000, 4'b0000);

        // Table: in_valid held high throughout, one result per cycle
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            @(posedge clk);
            #1;
            check_both($sformatf("vec%0d a=%0d b=%0d", i, vecs[i].a, vecs[i].b),
                       {1'b1, vecs[i].exp_u}, {1'b1, vecs[i].exp_s});
        end

        // Idle hold: flags keep the (3,0) result while inputs wander
        a = 2'd3;
        b = 2'd0;
        @(posedge clk);
        #1;
        check_both("hold setup 3,0", {1'b1, GT}, {1'b1, LT});
        in_valid = 1'b0;
        a        = 2'd1;
        b        = 2'd2;
        @(posedge clk);
        #1;
        check_both("idle hold 1", {1'b0, GT}, {1'b0, LT});
        a = 2'd2;
        b = 2'd2;
        @(posedge clk);
        #1;
        check_both("idle hold 2", {1'b0, GT}, {1'b0, LT});

        // Async reset mid-stream, between clock edges
        in_valid = 1'b1;
        a        = 2'd3;
        b        = 2'd3;
        @(posedge clk);
        #1;
        check_both("pre-reset result", {1'b1, EQ}, {1'b1, EQ});
        #1;
        rst_n = 1'b0;
        #1;
        check_both("async clear", 4'b0000, 4'b0000);
        a = 2'd0;
        b = 2'd1;
        @(posedge clk);
        #1;
        check_both("valid during reset", 4'b0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_both("first after reset", {1'b1, LT}, {1'b1, LT});
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_both("drop valid after reset", {1'b0, LT}, {1'b0, LT});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
